bbox_clip_unit: RTL



---
 rtl/bbox_clip_unit.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/bbox_clip_unit.sv
// Triangle bounding-box unit: floors vertex extents to pixels, clamps to a latched
// scissor, flags empty boxes and emits the covering tile range. One result per 4 cycles.
module bbox_clip_unit #(
    parameter int COORD_W   = 32,
    parameter int FRAC_BITS = 16,
    parameter int PIX_W     = 16,
    parameter int TILE_LOG2 = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3*COORD_W-1:0]         in_x,
    input  logic [3*COORD_W-1:0]         in_y,
    input  logic [PIX_W-1:0]             clip_xmin,
    input  logic [PIX_W-1:0]             clip_xmax,
    input  logic [PIX_W-1:0]             clip_ymin,
    input  logic [PIX_W-1:0]             clip_ymax,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PIX_W-1:0]             out_xmin,
    output logic [PIX_W-1:0]             out_xmax,
    output logic [PIX_W-1:0]             out_ymin,
    output logic [PIX_W-1:0]             out_ymax,
    output logic [PIX_W-TILE_LOG2-1:0]   out_tx0,
    output logic [PIX_W-TILE_LOG2-1:0]   out_tx1,
    output logic [PIX_W-TILE_LOG2-1:0]   out_ty0,
    output logic [PIX_W-TILE_LOG2-1:0]   out_ty1,
    output logic                         out_empty
);
    localparam int IW = COORD_W - FRAC_BITS + 1;
    // Compare width must also hold a zero-extended scissor value as positive.
    localparam int CW = (IW > PIX_W + 1) ? IW : PIX_W + 1;
    localparam int TW = PIX_W - TILE_LOG2;

    typedef enum logic [1:0] {IDLE, MINMAX, CLAMP, OUT} state_t;

    state_t                      state_q;
    logic                        in_ready_q, out_valid_q;
    logic [3*COORD_W-1:0]        x_q, y_q;
    logic [PIX_W-1:0]            cxmin_q, cxmax_q, cymin_q, cymax_q;
    logic signed [COORD_W-1:0]   xmn_q, xmx_q, ymn_q, ymx_q;
    logic signed [COORD_W-1:0]   xmn_d, xmx_d, ymn_d, ymx_d;
    logic [PIX_W-1:0]            out_xmin_q, out_xmax_q, out_ymin_q, out_ymax_q;
    logic [PIX_W-1:0]            out_xmin_d, out_xmax_d, out_ymin_d, out_ymax_d;
    logic [TW-1:0]               out_tx0_q, out_tx1_q, out_ty0_q, out_ty1_q;
    logic [TW-1:0]               out_tx0_d, out_tx1_d, out_ty0_d, out_ty1_d;
    logic                        out_empty_q, out_empty_d;
    logic signed [CW-1:0]        fxl, fxh, fyl, fyh, cxl, cxh, cyl, cyh;
    logic signed [CW-1:0]        lo_x, hi_x, lo_y, hi_y;

    function automatic logic signed [COORD_W-1:0] vmin(input logic [3*COORD_W-1:0] v);
        logic signed [COORD_W-1:0] m;
        m = $signed(v[0 +: COORD_W]);
        for (int i = 1; i < 3; i++)
            if ($signed(v[i*COORD_W +: COORD_W]) < m) m = $signed(v[i*COORD_W +: COORD_W]);
        return m;
    endfunction

    function automatic logic signed [COORD_W-1:0] vmax(input logic [3*COORD_W-1:0] v);
        logic signed [COORD_W-1:0] m;
        m = $signed(v[0 +: COORD_W]);
        for (int i = 1; i < 3; i++)
            if ($signed(v[i*COORD_W +: COORD_W]) > m) m = $signed(v[i*COORD_W +: COORD_W]);
        return m;
    endfunction

    // Arithmetic shift floors for both signs; result sign-extended to the compare width.
    function automatic logic signed [CW-1:0] to_pix(input logic signed [COORD_W-1:0] v);
        logic signed [COORD_W-1:0] s;
        s = v >>> FRAC_BITS;
        return CW'(s);
    endfunction

    always_comb begin
        xmn_d = vmin(x_q);
        xmx_d = vmax(x_q);
        ymn_d = vmin(y_q);
        ymx_d = vmax(y_q);
    end

    always_comb begin
        fxl  = to_pix(xmn_q);
        fxh  = to_pix(xmx_q);
        fyl  = to_pix(ymn_q);
        fyh  = to_pix(ymx_q);
        cxl  = $signed(CW'(cxmin_q));
        cxh  = $signed(CW'(cxmax_q));
        cyl  = $signed(CW'(cymin_q));
        cyh  = $signed(CW'(cymax_q));
        lo_x = (fxl > cxl) ? fxl : cxl;
        hi_x = (fxh < cxh) ? fxh : cxh;
        lo_y = (fyl > cyl) ? fyl : cyl;
        hi_y = (fyh < cyh) ? fyh : cyh;
        out_empty_d = (lo_x > hi_x) || (lo_y > hi_y);
        out_xmin_d  = lo_x[PIX_W-1:0];
        out_xmax_d  = hi_x[PIX_W-1:0];
        out_ymin_d  = lo_y[PIX_W-1:0];
        out_ymax_d  = hi_y[PIX_W-1:0];
        out_tx0_d   = out_empty_d ? '0 : out_xmin_d[PIX_W-1:TILE_LOG2];
        out_tx1_d   = out_empty_d ? '0 : out_xmax_d[PIX_W-1:TILE_LOG2];
        out_ty0_d   = out_empty_d ? '0 : out_ymin_d[PIX_W-1:TILE_LOG2];
        out_ty1_d   = out_empty_d ? '0 : out_ymax_d[PIX_W-1:TILE_LOG2];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            cxmin_q     <= '0;
            cxmax_q     <= '0;
            cymin_q     <= '0;
            cymax_q     <= '0;
            xmn_q       <= '0;
            xmx_q       <= '0;
            ymn_q       <= '0;
            ymx_q       <= '0;
            out_xmin_q  <= '0;
            out_xmax_q  <= '0;
            out_ymin_q  <= '0;
            out_ymax_q  <= '0;
            out_tx0_q   <= '0;
            out_tx1_q   <= '0;
            out_ty0_q   <= '0;
            out_ty1_q   <= '0;
            out_empty_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    x_q        <= in_x;
                    y_q        <= in_y;
                    cxmin_q    <= clip_xmin;
                    cxmax_q    <= clip_xmax;
                    cymin_q    <= clip_ymin;
                    cymax_q    <= clip_ymax;
                    in_ready_q <= 1'b0;
                    state_q    <= MINMAX;
                end
                MINMAX: begin
                    xmn_q   <= xmn_d;
                    xmx_q   <= xmx_d;
                    ymn_q   <= ymn_d;
                    ymx_q   <= ymx_d;
                    state_q <= CLAMP;
                end
                CLAMP: begin
                    out_xmin_q  <= out_xmin_d;
                    out_xmax_q  <= out_xmax_d;
                    out_ymin_q  <= out_ymin_d;
                    out_ymax_q  <= out_ymax_d;
                    out_tx0_q   <= out_tx0_d;
                    out_tx1_q   <= out_tx1_d;
                    out_ty0_q   <= out_ty0_d;
                    out_ty1_q   <= out_ty1_d;
                    out_empty_q <= out_empty_d;
                    out_valid_q <= 1'b1;
                    state_q     <= OUT;
                end
                OUT: if (out_ready) begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_xmin  = out_xmin_q;
    assign out_xmax  = out_xmax_q;
    assign out_ymin  = out_ymin_q;
    assign out_ymax  = out_ymax_q;
    assign out_tx0   = out_tx0_q;
    assign out_tx1   = out_tx1_q;
    assign out_ty0   = out_ty0_q;
    assign out_ty1   = out_ty1_q;
    assign out_empty = out_empty_q;
endmodule
